rule_cfg_bridge: RTL and testbench

RULE_CFG_BRIDGE -- requirements
Module: rule_cfg_bridge

---
 rtl/rule_cfg_bridge.sv | 115 +++++++++++
 tb/tb_rule_cfg_bridge.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/rule_cfg_bridge.sv
// Host-to-rule-table configuration bridge: parses header+data messages from a
// valid/ready word stream and issues addressed rule writes with done/err status.
module rule_cfg_bridge #(
    parameter logic [7:0] MAGIC = 8'hA5
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_cfg_valid,
    input  logic [31:0] i_cfg_data,
    input  logic        i_cfg_last,
    output logic        o_cfg_ready,
    output logic        o_rule_wren,
    output logic [31:0] o_rule_wdata,
    output logic [31:0] o_rule_addr,
    output logic        o_done,
    output logic        o_err,
    output logic [15:0] o_wr_cnt
);

    typedef enum logic [1:0] {IDLE, DATA, DRAIN} state_t;

    state_t      state_q, state_d;
    logic [7:0]  k_q, k_d, n_q, n_d;
    logic [15:0] b_q, b_d;
    logic        ready_q;
    logic        wren_q, wren_d, done_q, done_d, err_q, err_d;
    logic [31:0] wdata_q, wdata_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        acc, hdr_ok, last_word;

    assign acc       = i_cfg_valid & ready_q;
    assign hdr_ok    = (i_cfg_data[31:24] == MAGIC) && (i_cfg_data[23:16] != 8'd0) && !i_cfg_last;
    assign last_word = (k_q == 8'(n_q - 8'd1));

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        b_d     = b_q;
        wren_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        case (state_q)
            IDLE: if (acc) begin
                if (hdr_ok) begin
                    n_d     = i_cfg_data[23:16];
                    b_d     = i_cfg_data[15:0];
                    k_d     = 8'd0;
                    state_d = DATA;
                end else begin
                    err_d   = 1'b1;
                    state_d = i_cfg_last ? IDLE : DRAIN;
                end
            end
            DATA: if (acc) begin
                wren_d  = 1'b1;
                wdata_d = i_cfg_data;
                // 16-bit sum wraps naturally past 16'hFFFF
                addr_d  = b_q + {8'h00, k_q};
                k_d     = k_q + 8'd1;
                if (last_word) begin
                    done_d  = i_cfg_last;
                    err_d   = !i_cfg_last;
                    state_d = i_cfg_last ? IDLE : DRAIN;
                end else if (i_cfg_last) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            DRAIN: if (acc && i_cfg_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cnt_d = (wren_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            ready_q <= 1'b0;
            wren_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            wdata_q <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            b_q     <= b_d;
            ready_q <= 1'b1;
            wren_q  <= wren_d;
            done_q  <= done_d;
            err_q   <= err_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_cfg_ready  = ready_q;
    assign o_rule_wren  = wren_q;
    assign o_rule_wdata = wdata_q;
    assign o_rule_addr  = {16'h0000, addr_q};
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_wr_cnt     = cnt_q;

endmodule

// File: tb/tb_rule_cfg_bridge.sv
// Scoreboard bench for rule_cfg_bridge: message-level reference model pushes
// expected output events; a negedge monitor pops and compares them.
module tb_rule_cfg_bridge;
    localparam logic [7:0] MAGIC = 8'hA5;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        valid = 1'b0, last = 1'b0;
    logic [31:0] data = '0;
    logic        ready, wren, done, err;
    logic [31:0] wdata, addr;
    logic [15:0] wr_cnt;

    rule_cfg_bridge #(.MAGIC(MAGIC)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(valid), .i_cfg_data(data),
        .i_cfg_last(last), .o_cfg_ready(ready), .o_rule_wren(wren),
        .o_rule_wdata(wdata), .o_rule_addr(addr), .o_done(done), .o_err(err),
        .o_wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        wren, done, err;
        logic [31:0] wd;
        logic [15:0] ad;
        logic [15:0] cnt;
        int          cyc;
    } ev_t;

    ev_t         q[$];
    logic [31:0] dw[$];
    int          checks = 0, errors = 0;
    bit          gaps_on = 1'b0;

    // reference model state: what the outputs should hold
    logic [15:0] m_cnt = '0, m_ad = '0;
    logic [31:0] m_wd = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && (wren || done || err)) begin
            if (q.size() == 0) begin
                chk("unexpected_event", {61'd0, wren, done, err}, 64'd0);
            end else begin
                ev_t e;
                e = q.pop_front();
                chk("ev_cycle", 64'(cyc), 64'(e.cyc));
                chk("ev_wren", 64'(wren), 64'(e.wren));
                chk("ev_done", 64'(done), 64'(e.done));
                chk("ev_err", 64'(err), 64'(e.err));
                chk("ev_wdata", 64'(wdata), 64'(e.wd));
                chk("ev_addr", 64'(addr), {48'd0, e.ad});
                chk("ev_wr_cnt", 64'(wr_cnt), 64'(e.cnt));
            end
        end
    end

    task automatic push_ev(input logic w, input logic d, input logic e);
        ev_t ev;
        ev.wren = w; ev.done = d; ev.err = e;
        ev.wd = m_wd; ev.ad = m_ad; ev.cnt = m_cnt; ev.cyc = cyc;
        q.push_back(ev);
    endtask

    task automatic send_word(input logic [31:0] d, input logic l);
        int g, t;
        g = gaps_on ? $urandom_range(0, 2) : 0;
        repeat (g) begin
            valid = 1'b0; data = $urandom; last = 1'($urandom);
            @(posedge clk); #1;
        end
        t = 0;
        while (!ready && t < 20) begin
            @(posedge clk); #1; t++;
        end
        chk("cfg_ready", 64'(ready), 64'd1);
        valid = 1'b1; data = d; last = l;
        @(posedge clk); #1;
        valid = 1'b0; data = $urandom; last = 1'($urandom);
    endtask

    // Expected behaviour derived from message shape: with L data words and a
    // good header, min(L,N) writes happen; the final one carries done iff L==N.
    task automatic send_msg(input logic [7:0] op, input logic [7:0] n, input logic [15:0] b);
        int L, nw;
        L  = dw.size();
        nw = (op == MAGIC && n != 0 && L != 0) ? ((L < int'(n)) ? L : int'(n)) : 0;
        send_word({op, n, b}, L == 0);
        if (nw == 0) push_ev(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < L; i++) begin
            send_word(dw[i], i == L - 1);
            if (i < nw) begin
                if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                m_wd = dw[i];
                m_ad = 16'(b + 16'(i));
                push_ev(1'b1, (i == nw - 1) && (L == int'(n)), (i == nw - 1) && (L != int'(n)));
            end
        end
    endtask

    task automatic check_reset_outs(input string tag);
        @(negedge clk);
        chk({tag, "_ready"}, 64'(ready), 64'd0);
        chk({tag, "_wren"}, 64'(wren), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_err"}, 64'(err), 64'd0);
        chk({tag, "_wdata"}, 64'(wdata), 64'd0);
        chk({tag, "_addr"}, 64'(addr), 64'd0);
        chk({tag, "_wr_cnt"}, 64'(wr_cnt), 64'd0);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        m_cnt = '0; m_wd = '0; m_ad = '0;
        check_reset_outs(tag);
        chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic idle(input int c);
        repeat (c) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1;
        do_reset("por");

        // normal message, back-to-back
        dw = '{32'h11, 32'h22, 32'h33};
        send_msg(8'hA5, 8'd3, 16'h0010);
        idle(3);
        chk("normal_wr_cnt", 64'(wr_cnt), 64'd3);

        // address wrap
        dw = '{32'hDEAD_0001, 32'hDEAD_0002};
        send_msg(8'hA5, 8'd2, 16'hFFFF);
        // bad opcode, drained words, then a correct header
        dw = '{32'h1, 32'h2};
        send_msg(8'h5A, 8'd2, 16'h0100);
        dw = '{32'hCAFE};
        send_msg(8'hA5, 8'd1, 16'h0200);
        // N=0 header and header flagged last
        dw = '{32'h7};
        send_msg(8'hA5, 8'd0, 16'h0300);
        dw = '{};
        send_msg(8'hA5, 8'd2, 16'h0300);
        // short message
        dw = '{32'hAA, 32'hBB};
        send_msg(8'hA5, 8'd4, 16'h0400);
        // long message
        dw = '{32'hC1, 32'hC2, 32'hC3};
        send_msg(8'hA5, 8'd1, 16'h0500);
        idle(3);
        chk("directed_queue_empty", 64'(q.size()), 64'd0);

        // mid-message reset after the first of three data words
        send_word({8'hA5, 8'd3, 16'h0600}, 1'b0);
        send_word(32'h0000_6001, 1'b0);
        m_cnt = m_cnt + 16'd1; m_wd = 32'h0000_6001; m_ad = 16'h0600;
        push_ev(1'b1, 1'b0, 1'b0);
        idle(2);
        do_reset("midrst");
        idle(2);
        chk("midrst_no_event", {61'd0, wren, done, err}, 64'd0);
        dw = '{32'h71, 32'h72};
        send_msg(8'hA5, 8'd2, 16'h0700);
        idle(3);
        chk("post_reset_wr_cnt", 64'(wr_cnt), 64'd2);

        // randomized messages with idle gaps carrying junk on the bus
        gaps_on = 1'b1;
        for (int m = 0; m < 40; m++) begin
            logic [7:0]  op, n;
            logic [15:0] b;
            int          L;
            op = ($urandom_range(0, 3) != 0) ? MAGIC : 8'($urandom);
            n  = ($urandom_range(0, 7) != 0) ? 8'($urandom_range(1, 5)) : 8'd0;
            b  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF)) : 16'($urandom);
            L  = $urandom_range(0, 6);
            dw = '{};
            for (int i = 0; i < L; i++) dw.push_back($urandom);
            send_msg(op, n, b);
        end
        idle(4);
        chk("final_queue_empty", 64'(q.size()), 64'd0);
        chk("final_wr_cnt", 64'(wr_cnt), 64'(m_cnt));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
